draw_ball: RTL and testbench

// - Pixel-pipeline stage downstream of the ball position controller: overlays a BALL_DIAMETER

---
 rtl/pong_pkg.sv | 23 ++
 rtl/ball_span_rom.sv | 46 ++++
 rtl/draw_ball.sv | 138 +++++++++++++
 tb/tb_draw_ball.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared constants and types for the pong pixel pipeline stages.
package pong_pkg;

    localparam int BALL_DIAMETER = 16;
    localparam int RGB_W         = 12;
    localparam int CNT_W         = 11;
    localparam int POS_W         = 12;
    localparam int SCREEN_W      = 1024;
    localparam int SCREEN_H      = 768;

    localparam logic [RGB_W-1:0] BLACK = 12'h000;
    localparam logic [RGB_W-1:0] WHITE = 12'hFFF;

    typedef struct packed {
        logic [CNT_W-1:0] hcount;
        logic [CNT_W-1:0] vcount;
        logic             hsync;
        logic             vsync;
        logic             hblnk;
        logic             vblnk;
    } vga_timing_t;

endpackage

// File: rtl/ball_span_rom.sv
// Per-row {left,right} column span of a round ball; 1-cycle synchronous read.
// Only instantiated when DRAW_BALL_ROUND_EN is defined.
module ball_span_rom #(
    parameter int D  = 16,
    parameter int DW = $clog2(D)
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic [DW-1:0] row_i,
    output logic [DW-1:0] left_o,
    output logic [DW-1:0] right_o
);

    logic [3:0]    idx_s;
    logic [3:0]    l16_s;
    logic [3:0]    r16_s;
    logic [DW-1:0] left_d;
    logic [DW-1:0] right_d;

    // Circle table drawn on a 16x16 grid; other diameters rescale row and span.
    always_comb begin
        idx_s = 4'((int'(row_i) * 16) / D);
        case (idx_s)
            4'd0, 4'd15: begin l16_s = 4'd5; r16_s = 4'd10; end
            4'd1, 4'd14: begin l16_s = 4'd3; r16_s = 4'd12; end
            4'd2, 4'd13: begin l16_s = 4'd2; r16_s = 4'd13; end
            4'd3, 4'd12,
            4'd4, 4'd11: begin l16_s = 4'd1; r16_s = 4'd14; end
            default:     begin l16_s = 4'd0; r16_s = 4'd15; end
        endcase
        left_d  = DW'((int'(l16_s) * D) / 16);
        right_d = DW'(((int'(r16_s) + 1) * D) / 16 - 1);
    end

    // Registered read so the span lines up with the stage-1 pixel registers.
    always_ff @(posedge pclk) begin
        if (rst) begin
            left_o  <= '0;
            right_o <= '0;
        end else begin
            left_o  <= left_d;
            right_o <= right_d;
        end
    end

endmodule

// File: rtl/draw_ball.sv
// Overlays a ball on the VGA pixel stream with a fixed 2-cycle latency.
// Define DRAW_BALL_ROUND_EN for a round ball; otherwise the ball is a full square.
module draw_ball #(
    parameter int                           BALL_DIAMETER = pong_pkg::BALL_DIAMETER,
    parameter logic [pong_pkg::RGB_W-1:0]   BALL_COLOR    = pong_pkg::WHITE,
    parameter int                           LATENCY       = 2
) (
    input  logic                        pclk,
    input  logic                        rst,
    input  logic [pong_pkg::POS_W-1:0]  xpos,
    input  logic [pong_pkg::POS_W-1:0]  ypos,
    input  logic [pong_pkg::CNT_W-1:0]  hcount_in,
    input  logic [pong_pkg::CNT_W-1:0]  vcount_in,
    input  logic                        hsync_in,
    input  logic                        vsync_in,
    input  logic                        hblnk_in,
    input  logic                        vblnk_in,
    input  logic [pong_pkg::RGB_W-1:0]  rgb_in,
    output logic [pong_pkg::CNT_W-1:0]  hcount_out,
    output logic [pong_pkg::CNT_W-1:0]  vcount_out,
    output logic                        hsync_out,
    output logic                        vsync_out,
    output logic                        hblnk_out,
    output logic                        vblnk_out,
    output logic [pong_pkg::RGB_W-1:0]  rgb_out
);
    import pong_pkg::*;

    localparam int DW = $clog2(BALL_DIAMETER);

    logic              vblnk_q;
    logic [POS_W-1:0]  x_lat_q, x_lat_d;
    logic [POS_W-1:0]  y_lat_q, y_lat_d;
    logic [12:0]       dx_s, dy_s;
    logic              hit_s;
    vga_timing_t       tim_in_s;

    vga_timing_t       tim1_q;
    logic [RGB_W-1:0]  rgb1_q;
    logic              hit1_q;
    logic              blank1_q;
    logic              mask_s;

    vga_timing_t       tim2_q;
    logic [RGB_W-1:0]  rgb2_q, rgb2_d;

    // Position reloads only on the vblank rising edge so a frame never tears.
    always_comb begin
        if (vblnk_in && !vblnk_q) begin
            x_lat_d = xpos;
            y_lat_d = ypos;
        end else begin
            x_lat_d = x_lat_q;
            y_lat_d = y_lat_q;
        end
    end

    // Signed offsets; a negative or too-large offset is a miss, so no line wrap.
    always_comb begin
        dx_s     = {2'b00, hcount_in} - {1'b0, x_lat_q};
        dy_s     = {2'b00, vcount_in} - {1'b0, y_lat_q};
        hit_s    = !dx_s[12] && (dx_s < 13'(BALL_DIAMETER)) &&
                   !dy_s[12] && (dy_s < 13'(BALL_DIAMETER));
        tim_in_s = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                     vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};
    end

`ifdef DRAW_BALL_ROUND_EN
    logic [DW-1:0] col1_q;
    logic [DW-1:0] span_l_s, span_r_s;

    ball_span_rom #(.D(BALL_DIAMETER), .DW(DW)) u_span (
        .pclk    (pclk),
        .rst     (rst),
        .row_i   (dy_s[DW-1:0]),
        .left_o  (span_l_s),
        .right_o (span_r_s)
    );

    // Column captured alongside the row lookup for the stage-2 span compare.
    always_ff @(posedge pclk) begin
        if (rst) begin
            col1_q <= '0;
        end else begin
            col1_q <= dx_s[DW-1:0];
        end
    end

    assign mask_s = (col1_q >= span_l_s) && (col1_q <= span_r_s);
`else
    assign mask_s = 1'b1;
`endif

    // Stage-2 colour mux: blanking forces black ahead of the ball.
    always_comb begin
        if (blank1_q) begin
            rgb2_d = BLACK;
        end else if (hit1_q && mask_s) begin
            rgb2_d = BALL_COLOR;
        end else begin
            rgb2_d = rgb1_q;
        end
    end

    // Latch and both pipeline stages.
    always_ff @(posedge pclk) begin
        if (rst) begin
            vblnk_q  <= 1'b0;
            x_lat_q  <= '0;
            y_lat_q  <= '0;
            tim1_q   <= '0;
            rgb1_q   <= '0;
            hit1_q   <= 1'b0;
            blank1_q <= 1'b0;
            tim2_q   <= '0;
            rgb2_q   <= '0;
        end else begin
            vblnk_q  <= vblnk_in;
            x_lat_q  <= x_lat_d;
            y_lat_q  <= y_lat_d;
            tim1_q   <= tim_in_s;
            rgb1_q   <= rgb_in;
            hit1_q   <= hit_s;
            blank1_q <= hblnk_in | vblnk_in;
            tim2_q   <= tim1_q;
            rgb2_q   <= rgb2_d;
        end
    end

    assign hcount_out = tim2_q.hcount;
    assign vcount_out = tim2_q.vcount;
    assign hsync_out  = tim2_q.hsync;
    assign vsync_out  = tim2_q.vsync;
    assign hblnk_out  = tim2_q.hblnk;
    assign vblnk_out  = tim2_q.vblnk;
    assign rgb_out    = rgb2_q;

endmodule

// File: tb/tb_draw_ball.sv
// Randomised and directed bench for draw_ball against a geometric reference model.
module tb_draw_ball;

    localparam int D = 16;

    logic        pclk;
    logic        rst;
    logic [11:0] xpos, ypos;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    draw_ball dut (
        .pclk(pclk), .rst(rst), .xpos(xpos), .ypos(ypos),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int checks = 0;
    int passed = 0;

    // Reference state: where the ball is for the current frame, plus 2-deep output history.
    int          x_m = 0, y_m = 0;
    logic        pv_m = 1'b0;
    logic [11:0] s1_rgb = '0, o_rgb = '0;
    logic [25:0] s1_tim = '0, o_tim = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [11:0] model_pix();
        int  c, r;
        bit  inside_ball;
        c = int'(hcount_in) - x_m;
        r = int'(vcount_in) - y_m;
        inside_ball = (c >= 0) && (c < D) && (r >= 0) && (r < D);
`ifdef DRAW_BALL_ROUND_EN
        if ((2*c+1-D)*(2*c+1-D) + (2*r+1-D)*(2*r+1-D) > D*D) inside_ball = 1'b0;
`endif
        if (hblnk_in || vblnk_in) return 12'h000;
        if (inside_ball) return 12'hFFF;
        return rgb_in;
    endfunction

    task automatic tick();
        logic [11:0] px;
        logic [25:0] tm;
        @(posedge pclk);
        tm = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
        px = model_pix();
        if (rst) begin
            o_rgb = '0; o_tim = '0; s1_rgb = '0; s1_tim = '0;
            x_m = 0; y_m = 0; pv_m = 1'b0;
        end else begin
            o_rgb = s1_rgb; o_tim = s1_tim;
            s1_rgb = px;    s1_tim = tm;
            if (vblnk_in && !pv_m) begin
                x_m = int'(xpos);
                y_m = int'(ypos);
            end
            pv_m = vblnk_in;
        end
        #1;
        chk("model_rgb", 32'(rgb_out), 32'(o_rgb));
        chk("model_timing",
            32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
            32'(o_tim));
    endtask

    task automatic pix(input int hc, input int vc, input logic hb, input logic vb,
                       input logic [11:0] rgb);
        hcount_in = 11'(hc);
        vcount_in = 11'(vc);
        hblnk_in  = hb;
        vblnk_in  = vb;
        hsync_in  = 1'($urandom);
        vsync_in  = 1'($urandom);
        rgb_in    = rgb;
        tick();
    endtask

    // Drive one pixel, flush one cycle, then compare against a directed expectation.
    // sel: 0 = ball colour, 1 = rgb_in passthrough, 2 = black.
    task automatic probe(input string tag, input int hc, input int vc, input logic hb,
                         input int sel);
        logic [11:0] r, e;
        r = 12'($urandom);
        e = (sel == 0) ? 12'hFFF : (sel == 1) ? r : 12'h000;
        pix(hc, vc, hb, 1'b0, r);
        pix(0, 0, 1'b0, 1'b0, 12'($urandom));
        chk(tag, 32'(rgb_out), 32'(e));
    endtask

    task automatic load(input int x, input int y);
        xpos = 12'(x);
        ypos = 12'(y);
        pix(0, 768, 1'b0, 1'b1, 12'($urandom));
        xpos = 12'($urandom);
        ypos = 12'($urandom);
        pix(0, 769, 1'b0, 1'b1, 12'($urandom));
        pix(0, 0, 1'b0, 1'b0, 12'($urandom));
    endtask

    initial begin
        rst = 1'b1;
        xpos = 12'd0; ypos = 12'd0;
        hcount_in = 11'd0; vcount_in = 11'd0;
        hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
        rgb_in = 12'h000;

        // Reset held with live stimulus.
        for (int i = 0; i < 3; i++) begin
            xpos = 12'($urandom);
            ypos = 12'($urandom);
            pix(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                1'($urandom), 1'($urandom), 12'($urandom));
            chk("reset_rgb", 32'(rgb_out), 32'h0);
            chk("reset_hcount", 32'(hcount_out), 32'h0);
            chk("reset_sync", 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'h0);
        end
        rst = 1'b0;
        pix(50, 60, 1'b0, 1'b0, 12'h123);
        chk("post_reset_zero", 32'(rgb_out), 32'h0);
        pix(51, 61, 1'b0, 1'b0, 12'h456);
        chk("latency2_hcount", 32'(hcount_out), 32'd50);
        chk("latency2_vcount", 32'(vcount_out), 32'd60);

        // Ball at (100,200).
        load(100, 200);
`ifdef DRAW_BALL_ROUND_EN
        probe("corner_100_200", 100, 200, 1'b0, 1);
`else
        probe("corner_100_200", 100, 200, 1'b0, 0);
`endif
        probe("center_108_207", 108, 207, 1'b0, 0);
        probe("right_edge_116", 116, 200, 1'b0, 1);
        probe("bottom_edge_216", 100, 216, 1'b0, 1);

        // Position change mid-frame must not move the ball.
        xpos = 12'd300;
        pix(300, 400, 1'b0, 1'b0, 12'($urandom));
        probe("midframe_old_pos", 108, 207, 1'b0, 0);
        probe("midframe_new_pos", 308, 207, 1'b0, 1);
        probe("line_767", 308, 767, 1'b0, 1);
        load(300, 200);
        probe("next_frame_new", 308, 207, 1'b0, 0);
        probe("next_frame_old", 108, 207, 1'b0, 1);

        // Bottom-right corner: no wrap onto the next line.
        load(1022, 760);
        probe("corner_1022_765", 1022, 765, 1'b0, 0);
        probe("corner_1023_767", 1023, 767, 1'b0, 0);
        probe("nowrap_0_761", 0, 761, 1'b0, 1);
        probe("nowrap_13_761", 13, 761, 1'b0, 1);
        probe("blank_over_ball", 1022, 765, 1'b1, 2);

        // Random traffic, including occasional reloads and resets.
        for (int i = 0; i < 600; i++) begin
            int k;
            k = int'($urandom_range(0, 99));
            rst = (k == 0);
            xpos = 12'($urandom_range(0, 1100));
            ypos = 12'($urandom_range(0, 800));
            if (k < 6) begin
                pix(int'($urandom_range(0, 2047)), 770, 1'b0, 1'b1, 12'($urandom));
            end else if (k < 60) begin
                pix(x_m + int'($urandom_range(0, D + 7)) - 4,
                    y_m + int'($urandom_range(0, D + 7)) - 4,
                    ($urandom_range(0, 9) == 0), 1'b0, 12'($urandom));
            end else begin
                pix(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                    1'($urandom), 1'($urandom), 12'($urandom));
            end
        end
        rst = 1'b0;

        // Mid-frame reset returns the ball to (0,0) until the next vblank edge.
        pix(0, 0, 1'b0, 1'b0, 12'($urandom));
        load(500, 500);
        rst = 1'b1;
        pix(200, 300, 1'b0, 1'b0, 12'($urandom));
        rst = 1'b0;
`ifdef DRAW_BALL_ROUND_EN
        probe("after_reset_0_0", 0, 0, 1'b0, 1);
`else
        probe("after_reset_0_0", 0, 0, 1'b0, 0);
`endif
        probe("after_reset_5_0", 5, 0, 1'b0, 0);
        probe("after_reset_0_7", 0, 7, 1'b0, 0);
        probe("after_reset_old_pos", 508, 507, 1'b0, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
